// File: rtl/sv_uart_pkg.sv
// Shared types and constants for the word-assembling UART receiver.
package sv_uart_pkg;

  localparam int unsigned WORD_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  typedef logic [15:0] divider_t;

endpackage

// File: rtl/sv_uart_rx_deframer.sv
// 8N1 deframer: filters the raw line, finds start edges and shifts in one LSB-first byte
// per frame. Reports good bytes and framing errors as one-cycle registered strobes.
module sv_uart_rx_deframer
  import sv_uart_pkg::*;
#(
  parameter int unsigned RX_PIPE = 5
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  rx_i,
  input  divider_t              divider_i,
  output logic [WORD_WIDTH-1:0] byte_o,
  output logic                  byte_valid_o,
  output logic                  frame_err_o,
  output logic                  line_idle_o
);

  logic [RX_PIPE-1:0]    pipe_q, pipe_d;
  logic                  line_q, line_d;
  logic                  fall;
  rx_state_e             state_q, state_d;
  divider_t              div_q, div_d;
  divider_t              cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic                  stop_wait_q, stop_wait_d;
  logic                  byte_valid_q, byte_valid_d;
  logic                  frame_err_q, frame_err_d;

  // The filtered line only moves once every stage agrees, so short glitches vanish.
  always_comb begin
    pipe_d = {pipe_q[RX_PIPE-2:0], rx_i};
    line_d = line_q;
    if (&pipe_q) begin
      line_d = 1'b1;
    end else if (~|pipe_q) begin
      line_d = 1'b0;
    end
  end

  assign fall = line_q & ~|pipe_q;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    cnt_d        = cnt_q + 16'd1;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    stop_wait_d  = stop_wait_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fall) begin
          state_d = StStart;
          div_d   = divider_i;
          cnt_d   = 16'd1;
        end
      end
      StStart: begin
        if (cnt_q == (div_q >> 1)) begin
          cnt_d   = 16'd1;
          bit_d   = '0;
          state_d = line_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == div_q) begin
          cnt_d   = 16'd1;
          shreg_d = {line_q, shreg_q[WORD_WIDTH-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (stop_wait_q) begin
          cnt_d = cnt_q;
          if (line_q) begin
            stop_wait_d = 1'b0;
            state_d     = StIdle;
          end
        end else if (cnt_q == div_q) begin
          if (line_q) begin
            byte_valid_d = 1'b1;
            state_d      = StIdle;
          end else begin
            frame_err_d = 1'b1;
            stop_wait_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      pipe_q       <= '1;
      line_q       <= 1'b1;
      state_q      <= StIdle;
      div_q        <= '0;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      stop_wait_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      pipe_q       <= pipe_d;
      line_q       <= line_d;
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      stop_wait_q  <= stop_wait_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_o       = shreg_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;
  assign line_idle_o  = (state_q == StIdle);

endmodule

// File: rtl/sv_uart_rx_word.sv
// UART receiver that packs DATA_WIDTH/8 bytes (first byte most significant) into one
// AXI-Stream beat, with overrun, framing-error and inter-byte gap timeout reporting.
module sv_uart_rx_word
  import sv_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned RX_PIPE    = 5,
  parameter int unsigned GAP_BITS   = 20
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  irx,
  input  logic [15:0]           idivider,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  oframe_err,
  output logic                  ooverrun,
  output logic                  otimeout
);

  localparam int unsigned NumBytes = DATA_WIDTH / WORD_WIDTH;
  localparam int unsigned CntW     = $clog2(NumBytes);

  logic [WORD_WIDTH-1:0] rx_byte;
  logic                  rx_byte_valid;
  logic                  rx_frame_err;
  logic                  rx_line_idle;

  logic [CntW-1:0]       bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  ovr_q, ovr_d;
  logic                  tmo_q, tmo_d;
  logic [31:0]           gap_q, gap_d;
  logic [31:0]           gap_limit;

  sv_uart_rx_deframer #(
    .RX_PIPE(RX_PIPE)
  ) u_deframer (
    .iclk        (iclk),
    .irst        (irst),
    .rx_i        (irx),
    .divider_i   (idivider),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_byte_valid),
    .frame_err_o (rx_frame_err),
    .line_idle_o (rx_line_idle)
  );

  assign gap_limit = GAP_BITS * {16'd0, idivider};

  always_comb begin
    bcnt_d   = bcnt_q;
    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ovr_d    = 1'b0;
    tmo_d    = 1'b0;
    gap_d    = gap_q;

    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    // Gap is measured from the last byte strobe; any frame activity restarts it.
    if (!rx_line_idle || rx_byte_valid) begin
      gap_d = '0;
    end else if (gap_q != '1) begin
      gap_d = gap_q + 32'd1;
    end

    if (rx_frame_err) begin
      bcnt_d = '0;
    end else if (rx_byte_valid) begin
      acc_d[(DATA_WIDTH - WORD_WIDTH) - WORD_WIDTH * int'(bcnt_q) +: WORD_WIDTH] = rx_byte;
      if (bcnt_q == CntW'(NumBytes - 1)) begin
        bcnt_d = '0;
        if (!tvalid_q || m_axis_tready) begin
          tdata_d  = acc_d;
          tvalid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        bcnt_d = bcnt_q + CntW'(1);
      end
    end else if ((bcnt_q != '0) && (gap_q >= gap_limit)) begin
      bcnt_d = '0;
      tmo_d  = 1'b1;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      bcnt_q   <= '0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
      gap_q    <= '0;
    end else begin
      bcnt_q   <= bcnt_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovr_q    <= ovr_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign oframe_err    = rx_frame_err;
  assign ooverrun      = ovr_q;
  assign otimeout      = tmo_q;

endmodule

// File: tb/tb_sv_uart_rx_word.sv
// Directed bench for sv_uart_rx_word: 24-bit words, divider 16, five-stage line filter.
module tb_sv_uart_rx_word;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        irx = 1'b1;
  logic [15:0] idivider = 16'd16;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        oframe_err;
  logic        ooverrun;
  logic        otimeout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_start_cyc = 0;
  int rise_cyc = -1;
  int n_beats = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_tmo = 0;
  int n_busy = 0;
  logic [23:0] last_beat = '0;
  logic tvalid_prev = 1'b0;
  logic mon_en = 1'b0;

  sv_uart_rx_word dut (
    .iclk         (iclk),
    .irst         (irst),
    .irx          (irx),
    .idivider     (idivider),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .oframe_err   (oframe_err),
    .ooverrun     (ooverrun),
    .otimeout     (otimeout)
  );

  always #5 iclk = ~iclk;

  always @(posedge iclk) cyc <= cyc + 1;

  always @(negedge iclk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      n_beats++;
      last_beat = m_axis_tdata;
    end
    if (m_axis_tvalid && !tvalid_prev) rise_cyc = cyc;
    tvalid_prev = m_axis_tvalid;
    if (oframe_err) n_ferr++;
    if (ooverrun) n_ovr++;
    if (otimeout) n_tmo++;
    if (mon_en && !dut.u_deframer.line_idle_o) n_busy++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic v, input int n);
    irx = v;
    repeat (n) @(posedge iclk);
    #1;
  endtask

  // rst_bit >= 0 pulses irst halfway through that data bit and abandons the frame.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int rst_bit);
    @(posedge iclk);
    #1;
    last_start_cyc = cyc;
    bit_out(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        bit_out(data[i], 8);
        irst = 1'b1;
        irx  = 1'b1;
        repeat (2) @(posedge iclk);
        #1;
        irst = 1'b0;
        return;
      end
      bit_out(data[i], 16);
    end
    bit_out(stop_bit, 16);
    irx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (4) @(posedge iclk);
    @(negedge iclk);
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check_eq("rst_pulses", 32'(n_ferr + n_ovr + n_tmo), 32'd0);
    @(posedge iclk);
    #1;
    irst = 1'b0;
    idle(10);

    // Three back-to-back bytes, downstream always ready
    send_frame(8'hA5, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'h0F, 1'b1, -1);
    idle(20);
    check_eq("basic_beats", 32'(n_beats), 32'd1);
    check_eq("basic_data", 32'(last_beat), 32'hA53C0F);
    check_eq("basic_latency", 32'(rise_cyc - last_start_cyc), 32'd159);

    // Backpressure: second word is dropped
    m_axis_tready = 1'b0;
    for (int b = 1; b <= 6; b++) send_frame(8'(b), 1'b1, -1);
    idle(20);
    check_eq("ovr_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_eq("ovr_tdata", 32'(m_axis_tdata), 32'h010203);
    check_eq("ovr_pulse", 32'(n_ovr), 32'd1);
    check_eq("ovr_no_beat", 32'(n_beats), 32'd1);
    m_axis_tready = 1'b1;
    idle(5);
    check_eq("ovr_beats", 32'(n_beats), 32'd2);
    check_eq("ovr_beat_data", 32'(last_beat), 32'h010203);
    check_eq("ovr_tvalid_clr", 32'(m_axis_tvalid), 32'd0);

    // Gap timeout discards a partial word
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    idle(320);
    send_frame(8'h33, 1'b1, -1);
    send_frame(8'h44, 1'b1, -1);
    send_frame(8'h55, 1'b1, -1);
    idle(20);
    check_eq("tmo_pulse", 32'(n_tmo), 32'd1);
    check_eq("tmo_beats", 32'(n_beats), 32'd3);
    check_eq("tmo_data", 32'(last_beat), 32'h334455);

    // Framing error discards a partial word without a timeout
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b0, -1);
    idle(32);
    send_frame(8'hAA, 1'b1, -1);
    send_frame(8'hBB, 1'b1, -1);
    send_frame(8'hCC, 1'b1, -1);
    idle(20);
    check_eq("ferr_pulse", 32'(n_ferr), 32'd1);
    check_eq("ferr_beats", 32'(n_beats), 32'd4);
    check_eq("ferr_data", 32'(last_beat), 32'hAABBCC);
    check_eq("ferr_no_tmo", 32'(n_tmo), 32'd1);

    // Short glitch is filtered out; 6-cycle pulse starts a frame that aborts mid-bit
    mon_en = 1'b1;
    bit_out(1'b0, 2);
    bit_out(1'b1, 40);
    check_eq("glitch_busy", 32'(n_busy), 32'd0);
    bit_out(1'b0, 6);
    bit_out(1'b1, 40);
    check_eq("pulse6_busy", 32'(n_busy), 32'd8);
    mon_en = 1'b0;
    check_eq("glitch_pulses", 32'(n_ferr + n_ovr + n_tmo), 32'd3);
    check_eq("glitch_beats", 32'(n_beats), 32'd4);

    // Reset mid-frame, then a clean word
    send_frame(8'h01, 1'b1, -1);
    send_frame(8'h02, 1'b1, 1);
    check_eq("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("mid_rst_tdata", 32'(m_axis_tdata), 32'd0);
    idle(40);
    send_frame(8'h07, 1'b1, -1);
    send_frame(8'h08, 1'b1, -1);
    send_frame(8'h09, 1'b1, -1);
    idle(20);
    check_eq("post_rst_beats", 32'(n_beats), 32'd5);
    check_eq("post_rst_data", 32'(last_beat), 32'h070809);
    check_eq("post_rst_pulses", 32'(n_ferr + n_ovr + n_tmo), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
